// File: rtl/mode_sequencer_if.sv
// Command/status bundle between the key decoder (master) and mode_sequencer (slave).
// NUM_STATES must match the attached mode_sequencer so that `state` widths agree.
interface mode_sequencer_if #(
  parameter int unsigned NUM_STATES = 4
);
  localparam int unsigned STATE_W = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;

  logic [1:0]         in;
  logic [STATE_W-1:0] state;
  logic               changed;
  logic               wrapped;

  modport master (output in, input state, changed, wrapped);
  modport slave  (input in, output state, changed, wrapped);
endinterface

// File: rtl/mode_sequencer.sv
// Mode index sequencer: steps `state` forward/backward on edge-detected command codes,
// wraps at both ends, and clears on a level-sensitive clear code.
// Optional feature macro: MODE_SEQ_AUTOREPEAT_EN adds hold-to-repeat stepping.
module mode_sequencer #(
  parameter int unsigned NUM_STATES    = 4,
  parameter logic [1:0]  ADV_CODE      = 2'b10,
  parameter logic [1:0]  BACK_CODE     = 2'b01,
  parameter logic [1:0]  CLR_CODE      = 2'b11,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input logic             clk,
  input logic             rst,
  mode_sequencer_if.slave bus
);
  localparam int unsigned STATE_W = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam logic [STATE_W-1:0] LastState = STATE_W'(NUM_STATES - 1);

  if (NUM_STATES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("mode_sequencer: NUM_STATES must be >= 2, HOLD/REPEAT_CYCLES >= 1");
  end

  logic [STATE_W-1:0] r_state;
  logic               r_changed;
  logic               r_wrapped;
  logic [1:0]         r_in_d;

  logic w_adv_press;
  logic w_back_press;
  logic w_clr;
  logic w_step_adv;
  logic w_step_back;

  assign w_adv_press  = (bus.in == ADV_CODE)  && (r_in_d != ADV_CODE);
  assign w_back_press = (bus.in == BACK_CODE) && (r_in_d != BACK_CODE);
  assign w_clr        = (bus.in == CLR_CODE);

`ifdef MODE_SEQ_AUTOREPEAT_EN
  localparam int unsigned MaxCycles = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  // r_cnt counts edges since the last step of the current hold; r_rep marks that the
  // first (long) hold interval has already elapsed.
  logic [CntW-1:0] r_cnt;
  logic            r_rep;
  logic [CntW-1:0] w_target;
  logic            w_held;
  logic            w_fire;

  assign w_held   = (bus.in == r_in_d) && ((bus.in == ADV_CODE) || (bus.in == BACK_CODE));
  assign w_target = r_rep ? CntW'(REPEAT_CYCLES - 1) : CntW'(HOLD_CYCLES - 1);
  assign w_fire   = w_held && (r_cnt == w_target);

  // Repeat timer: runs only while a step code is held unchanged, cleared otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rep <= 1'b0;
    end else if (w_held) begin
      if (w_fire) begin
        r_cnt <= '0;
        r_rep <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
      r_rep <= 1'b0;
    end
  end

  assign w_step_adv  = w_adv_press  || (w_fire && (bus.in == ADV_CODE));
  assign w_step_back = w_back_press || (w_fire && (bus.in == BACK_CODE));
`else
  assign w_step_adv  = w_adv_press;
  assign w_step_back = w_back_press;
`endif

  // Mode register with one-cycle changed/wrapped pulses; clear beats any step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= '0;
      r_changed <= 1'b0;
      r_wrapped <= 1'b0;
      r_in_d    <= 2'b00;
    end else begin
      r_in_d    <= bus.in;
      r_changed <= 1'b0;
      r_wrapped <= 1'b0;
      if (w_clr) begin
        r_state   <= '0;
        r_changed <= (r_state != '0);
      end else if (w_step_adv) begin
        r_changed <= 1'b1;
        // Out-of-range values recover to 0 without a wrap pulse.
        if (r_state >= LastState) begin
          r_state   <= '0;
          r_wrapped <= (r_state == LastState);
        end else begin
          r_state <= r_state + 1'b1;
        end
      end else if (w_step_back) begin
        r_changed <= 1'b1;
        if (r_state == '0) begin
          r_state   <= LastState;
          r_wrapped <= 1'b1;
        end else if (r_state > LastState) begin
          r_state <= LastState;
        end else begin
          r_state <= r_state - 1'b1;
        end
      end
    end
  end

  assign bus.state   = r_state;
  assign bus.changed = r_changed;
  assign bus.wrapped = r_wrapped;
endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: two instances (4 and 5 modes) share one command stream and are
// checked every cycle against a behavioural model, plus literal scenario checks.
module tb_mode_sequencer;
  localparam int unsigned Hold = 5;
  localparam int unsigned Rep  = 3;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [1:0] in_v = 2'b10;

  always #5 clk = ~clk;

  mode_sequencer_if #(.NUM_STATES(4)) bus4 ();
  mode_sequencer_if #(.NUM_STATES(5)) bus5 ();

  assign bus4.in = in_v;
  assign bus5.in = in_v;

  mode_sequencer #(
    .NUM_STATES(4), .HOLD_CYCLES(Hold), .REPEAT_CYCLES(Rep)
  ) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );

  mode_sequencer #(
    .NUM_STATES(5), .HOLD_CYCLES(Hold), .REPEAT_CYCLES(Rep)
  ) u_dut5 (
    .clk(clk), .rst(rst), .bus(bus5.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: index 0 -> 4 modes, index 1 -> 5 modes.
  int         m_n[2] = '{4, 5};
  int         m_st[2];
  int         m_ch[2];
  int         m_wr[2];
  int         m_k[2];     // edges since the press of the current hold
  logic [1:0] m_prev[2];

  function automatic bit repeat_due(int k);
`ifdef MODE_SEQ_AUTOREPEAT_EN
    return (k == Hold) || ((k > Hold) && (((k - Hold) % Rep) == 0));
`else
    return (k < 0);
`endif
  endfunction

  function automatic void model_step(int i, int dir);
    m_wr[i] = ((dir == 1) && (m_st[i] == m_n[i] - 1)) || ((dir == -1) && (m_st[i] == 0));
    m_st[i] = (m_st[i] + dir + m_n[i]) % m_n[i];
    m_ch[i] = 1;
  endfunction

  // Model update at each edge, then compare both instances just after it.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_st[i] = 0; m_ch[i] = 0; m_wr[i] = 0; m_k[i] = 0; m_prev[i] = 2'b00;
      end else begin
        m_ch[i] = 0;
        m_wr[i] = 0;
        if (in_v == 2'b11) begin
          m_ch[i] = (m_st[i] != 0);
          m_st[i] = 0;
          m_k[i]  = 0;
        end else if (in_v == 2'b10 || in_v == 2'b01) begin
          if (m_prev[i] != in_v) begin
            m_k[i] = 0;
            model_step(i, (in_v == 2'b10) ? 1 : -1);
          end else begin
            m_k[i]++;
            if (repeat_due(m_k[i])) model_step(i, (in_v == 2'b10) ? 1 : -1);
          end
        end else begin
          m_k[i] = 0;
        end
        m_prev[i] = in_v;
      end
    end
    #1;
    chk("state4",   int'(bus4.state),   m_st[0]);
    chk("changed4", int'(bus4.changed), m_ch[0]);
    chk("wrapped4", int'(bus4.wrapped), m_wr[0]);
    chk("state5",   int'(bus5.state),   m_st[1]);
    chk("changed5", int'(bus5.changed), m_ch[1]);
    chk("wrapped5", int'(bus5.wrapped), m_wr[1]);
  end

  task automatic tick(input logic [1:0] v, input logic r);
    @(negedge clk);
    in_v = v;
    rst  = r;
    @(posedge clk);
    #2;
  endtask

  int pulses;

  initial begin
    // Reset held with ADV present, then released with ADV still held.
    repeat (3) tick(2'b10, 1'b1);
    chk("rst_state",   int'(bus4.state),   0);
    chk("rst_changed", int'(bus4.changed), 0);
    chk("rst_wrapped", int'(bus4.wrapped), 0);
    tick(2'b10, 1'b0);
    chk("post_rst_press4", int'(bus4.state), 1);
    chk("post_rst_press5", int'(bus5.state), 1);
    tick(2'b00, 1'b0);
    tick(2'b11, 1'b0);
    chk("clr_state", int'(bus4.state), 0);
    chk("clr_changed", int'(bus4.changed), 1);
    tick(2'b00, 1'b0);

    // Forward wrap on 4 modes.
    pulses = 0;
    for (int p = 1; p <= 4; p++) begin
      tick(2'b10, 1'b0);
      pulses += int'(bus4.changed);
      chk("fwd_state4", int'(bus4.state), p % 4);
      chk("fwd_wrap4", int'(bus4.wrapped), (p == 4) ? 1 : 0);
      tick(2'b00, 1'b0);
    end
    chk("fwd_pulses4", pulses, 4);
    chk("fwd_state5", int'(bus5.state), 4);

    // Backward and forward wrap on 5 modes, then ADV->BACK without a gap.
    tick(2'b11, 1'b0);
    tick(2'b00, 1'b0);
    tick(2'b01, 1'b0);
    chk("back_state5", int'(bus5.state), 4);
    chk("back_wrap5", int'(bus5.wrapped), 1);
    tick(2'b00, 1'b0);
    tick(2'b10, 1'b0);
    chk("adv_state5", int'(bus5.state), 0);
    chk("adv_wrap5", int'(bus5.wrapped), 1);
    tick(2'b01, 1'b0);
    chk("nogap_state5", int'(bus5.state), 4);
    tick(2'b00, 1'b0);

    tick(2'b11, 1'b0);
    tick(2'b00, 1'b0);
`ifndef MODE_SEQ_AUTOREPEAT_EN
    // Level hold gives one step; clear pulses once while held.
    pulses = 0;
    repeat (20) begin
      tick(2'b10, 1'b0);
      pulses += int'(bus4.changed);
    end
    chk("hold_state4", int'(bus4.state), 1);
    chk("hold_pulses4", pulses, 1);
    tick(2'b11, 1'b0);
    chk("hold_clr_state4", int'(bus4.state), 0);
    chk("hold_clr_changed4", int'(bus4.changed), 1);
    pulses = 0;
    repeat (3) begin
      tick(2'b11, 1'b0);
      pulses += int'(bus4.changed);
    end
    chk("hold_clr_pulses4", pulses, 0);
`else
    // Auto-repeat: steps at edges 0, 5, 8, 11 of the hold.
    pulses = 0;
    for (int e = 0; e < 12; e++) begin
      tick(2'b10, 1'b0);
      pulses += int'(bus4.changed);
      if (e == 5) chk("rep_edge5_state4", int'(bus4.state), 2);
    end
    chk("rep_state4", int'(bus4.state), 0);
    chk("rep_pulses4", pulses, 4);
    pulses = 0;
    repeat (2) begin
      tick(2'b00, 1'b0);
      pulses += int'(bus4.changed);
    end
    chk("rep_release_pulses4", pulses, 0);
    // Reset mid-hold restarts the hold interval from the post-reset press.
    repeat (3) tick(2'b10, 1'b0);
    tick(2'b10, 1'b1);
    chk("rep_rst_state4", int'(bus4.state), 0);
    tick(2'b10, 1'b0);
    chk("rep_rst_press4", int'(bus4.state), 1);
    repeat (4) tick(2'b10, 1'b0);
    chk("rep_rst_wait4", int'(bus4.state), 1);
    tick(2'b10, 1'b0);
    chk("rep_rst_first4", int'(bus4.state), 2);
`endif
    tick(2'b00, 1'b0);

    // Randomised runs of held codes with occasional resets.
    repeat (300) begin
      logic [1:0] v;
      int         len;
      logic       rr;
      v   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 14);
      rr  = ($urandom_range(0, 40) == 0);
      for (int c = 0; c < len; c++) tick(v, (c == 0) ? rr : 1'b0);
    end

    tick(2'b00, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Parametrised successor to the 4-state mode selector. Steps a mode index through NUM_STATES values on edge-detected input codes, in both directions, with wrap-around and a synchronous clear code. Optionally auto-repeats while a step code is held. Sits between the debounced button/key decoder and the mode-dependent datapath, which consumes `state` directly.

## Interface
- NUM_STATES, 4: number of modes, ≥2; `state` width STATE_W = $clog2(NUM_STATES) (localparam).
- ADV_CODE, 2'b10: `in` value that steps forward.
- BACK_CODE, 2'b01: `in` value that steps backward.
- CLR_CODE, 2'b11: `in` value that forces state 0.
- HOLD_CYCLES, 50_000_000: cycles from press to first auto-repeat, ≥1 (macro builds only).
- REPEAT_CYCLES, 10_000_000: cycles between later auto-repeats, ≥1 (macro builds only).
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  2  command code, sampled every clk edge; 2'b00 = idle.
- state  out  STATE_W  current mode index, registered.
- changed  out  1  one-cycle pulse, high for the cycle after any edge at which `state` changed value.
- wrapped  out  1  one-cycle pulse, high for the cycle after a wrap step (NUM_STATES-1→0 forward, 0→NUM_STATES-1 backward).

## Operation
- Reset (rst=1 at an edge): state=0, changed=0, wrapped=0, previous-input register in_d=2'b00, repeat counter=0. Reset overrides all commands.
- in_d holds `in` as sampled at the previous edge.
- Press event for code C at an edge: in==C and in_d!=C. A direct ADV→BACK change is a fresh BACK press.
- CLR_CODE is level-sensitive: every edge with in==CLR_CODE loads state=0. changed=1 only if state was non-zero. wrapped=0. Counter cleared.
- ADV press: state = (state==NUM_STATES-1) ? 0 : state+1. wrapped=1 on the wrap step.
- BACK press: state = (state==0) ? NUM_STATES-1 : state-1. wrapped=1 on the wrap step.
- Any other `in` value, including codes outside the three defined, holds state. changed=0, wrapped=0.
- A step always changes state (NUM_STATES≥2), so changed=1 on every step.
- Values of `state` ≥ NUM_STATES are unreachable. If one is forced, the next ADV step loads 0 and the next BACK step loads NUM_STATES-1, with no wrapped pulse.

## Timing
- Latency: a press sampled at edge t updates `state`, `changed` and `wrapped` at that same edge t. The outputs are visible in the cycle following t.
- changed/wrapped are high for exactly one cycle per step, never stretched.
- A level held on ADV/BACK produces one step (without the macro). Releasing to 2'b00 for at least one sampled edge re-arms the press detect.
- rst asserted in the middle of a hold: the next edge after rst deasserts sees in_d=2'b00. If the code is still held, that edge counts as a press.

## Configuration
- MODE_SEQ_AUTOREPEAT_EN defined: while ADV_CODE or BACK_CODE stays held continuously after a press at edge t0, repeat steps occur at edges t0+HOLD_CYCLES, then every REPEAT_CYCLES after that.
  - Counter width is $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1).
  - The counter clears on any press, on release, on a code change, on CLR, and on reset.
  - Repeat steps behave exactly like press steps: changed pulses, and wrapped pulses on a wrap.
- Not defined: no counter logic is built. HOLD_CYCLES and REPEAT_CYCLES are accepted and ignored. A held code yields exactly one step.

## Test plan
- Reset: hold rst=1 for 3 edges with in=2'b10 → state=0, changed=0, wrapped=0. After rst falls with in still 2'b10 → state=1 one cycle later.
- Forward wrap, NUM_STATES=4: four ADV presses, each 1 cycle with 2'b00 gaps → state 1,2,3,0. changed pulses 4 times. wrapped pulses only on 3→0.
- Backward/non-power-of-2, NUM_STATES=5: from 0, BACK press → state=4, wrapped=1. Then ADV press → state=0, wrapped=1. Then in=2'b10→2'b01 with no gap → state=4.
- Level hold and clear, no macro: hold in=2'b10 for 20 cycles from state 0 → state=1 only, one changed pulse. Then in=2'b11 → state=0, changed=1 once. Hold 2'b11 further → no more pulses.
- Auto-repeat, macro on, HOLD_CYCLES=5, REPEAT_CYCLES=3, NUM_STATES=4: hold ADV 12 edges from state 0 → steps at edges 0, 5, 8, 11, giving state 1,2,3,0. Release for 2 edges → no steps.
- Reset in the middle of a repeat: macro on, assert rst for 1 edge mid-hold → state=0. The counter restarts from the post-reset press, so the first repeat comes HOLD_CYCLES edges after that press.
